// File: rtl/reduxv_pkg.sv
// Shared ReduxV definitions: next-PC mode encodings and default PC width.
package reduxv_pkg;

  localparam int unsigned PC_W_DEFAULT = 8;
  localparam int unsigned PCSRC_W      = 3;

  localparam logic [PCSRC_W-1:0] BRZR   = 3'b000;
  localparam logic [PCSRC_W-1:0] CALL   = 3'b001;
  localparam logic [PCSRC_W-1:0] RET    = 3'b010;
  localparam logic [PCSRC_W-1:0] BRZI   = 3'b100;
  localparam logic [PCSRC_W-1:0] JI     = 3'b101;
  localparam logic [PCSRC_W-1:0] NO_JMP = 3'b110;

endpackage : reduxv_pkg

// File: rtl/ras_stack.sv
// Return-address LIFO; push while full and pop while empty are silently ignored.
module ras_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign wr_idx  = IW'(count_q);
  assign rd_idx  = IW'(count_q - CW'(1));
  assign top     = empty ? '0 : mem_q[rd_idx];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: only slots below count_q are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule : ras_stack

// File: rtl/pc_unit.sv
// Registered program counter with branch/jump/call/return selection and a
// hardware return-address stack with sticky overflow/underflow flags.
module pc_unit
  import reduxv_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEFAULT,
  parameter int unsigned RAS_DEPTH = 4,
  parameter int unsigned RESET_PC  = 0,
  localparam int unsigned CW       = $clog2(RAS_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [PCSRC_W-1:0] pcsrc,
  input  logic               zero,
  input  logic [PC_W-1:0]    brzr_pc,
  input  logic [PC_W-1:0]    brzi_pc,
  input  logic [PC_W-1:0]    ji_pc,
  output logic [PC_W-1:0]    pc,
  output logic [CW-1:0]      ras_count,
  output logic               ras_ovf,
  output logic               ras_unf
);

  logic [PC_W-1:0] pc_q, pc_d, std_pc, ras_top;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            push, pop, ras_full, ras_empty;

  assign std_pc = pc_q + PC_W'(1);

  ras_stack #(
    .WIDTH (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (std_pc),
    .top   (ras_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  // Mode decode; with en low nothing moves, including the stack.
  always_comb begin
    pc_d  = pc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (en) begin
      case (pcsrc)
        BRZR: pc_d = zero ? brzr_pc : std_pc;
        BRZI: pc_d = zero ? brzi_pc : std_pc;
        JI:   pc_d = ji_pc;
        CALL: begin
          pc_d = ji_pc;
          if (ras_full) begin
            ovf_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        RET: begin
          if (ras_empty) begin
            pc_d  = std_pc;
            unf_d = 1'b1;
          end else begin
            pc_d = ras_top;
            pop  = 1'b1;
          end
        end
        default: pc_d = std_pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= PC_W'(RESET_PC);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign pc      = pc_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule : pc_unit

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (PC_W=8, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_unit;

  localparam logic [2:0] M_BRZR = 3'b000;
  localparam logic [2:0] M_CALL = 3'b001;
  localparam logic [2:0] M_RET  = 3'b010;
  localparam logic [2:0] M_ODD  = 3'b011;
  localparam logic [2:0] M_BRZI = 3'b100;
  localparam logic [2:0] M_JI   = 3'b101;
  localparam logic [2:0] M_NOJ  = 3'b110;

  logic       clk = 1'b0;
  logic       rst, en, zero;
  logic [2:0] pcsrc;
  logic [7:0] brzr_pc, brzi_pc, ji_pc;
  logic [7:0] pc;
  logic [2:0] ras_count;
  logic       ras_ovf, ras_unf;

  int tests = 0;
  int fails = 0;

  pc_unit #(.PC_W(8), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pcsrc     (pcsrc),
    .zero      (zero),
    .brzr_pc   (brzr_pc),
    .brzi_pc   (brzi_pc),
    .ji_pc     (ji_pc),
    .pc        (pc),
    .ras_count (ras_count),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] src, input logic z,
                      input logic [7:0] ji, input int exp_pc, input int exp_cnt);
    pcsrc = src;
    zero  = z;
    ji_pc = ji;
    @(posedge clk);
    #1;
    check({tag, ".pc"}, int'(pc), exp_pc);
    check({tag, ".cnt"}, int'(ras_count), exp_cnt);
  endtask

  task automatic flags(input string tag, input int exp_ovf, input int exp_unf);
    check({tag, ".ovf"}, int'(ras_ovf), exp_ovf);
    check({tag, ".unf"}, int'(ras_unf), exp_unf);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; zero = 1'b0; pcsrc = M_NOJ;
    brzr_pc = 8'd13; brzi_pc = 8'd12; ji_pc = 8'd0;
    @(posedge clk); #1;
    step("reset", M_JI, 1'b1, 8'd77, 0, 0);
    flags("reset", 0, 0);
    rst = 1'b0;

    // wrap
    step("to255", M_JI, 1'b0, 8'd255, 255, 0);
    step("wrap", M_NOJ, 1'b0, 8'd0, 0, 0);

    // branches from pc=10
    step("to10a", M_JI, 1'b0, 8'd10, 10, 0);
    step("brzr_z0", M_BRZR, 1'b0, 8'd11, 11, 0);
    step("to10b", M_JI, 1'b0, 8'd10, 10, 0);
    step("brzr_z1", M_BRZR, 1'b1, 8'd11, 13, 0);
    step("to10c", M_JI, 1'b0, 8'd10, 10, 0);
    step("brzi_z0", M_BRZI, 1'b0, 8'd11, 11, 0);
    step("to10d", M_JI, 1'b0, 8'd10, 10, 0);
    step("brzi_z1", M_BRZI, 1'b1, 8'd11, 12, 0);
    step("to10e", M_JI, 1'b0, 8'd10, 10, 0);
    step("ji_z1", M_JI, 1'b1, 8'd11, 11, 0);
    step("mode011", M_ODD, 1'b1, 8'd90, 12, 0);
    step("mode111", 3'b111, 1'b1, 8'd90, 13, 0);

    // call / return
    step("to20", M_JI, 1'b0, 8'd20, 20, 0);
    step("call40", M_CALL, 1'b0, 8'd40, 40, 1);
    step("call60", M_CALL, 1'b0, 8'd60, 60, 2);
    step("ret41", M_RET, 1'b0, 8'd0, 41, 1);
    step("ret21", M_RET, 1'b0, 8'd0, 21, 0);
    flags("callret", 0, 0);

    // overflow: pushes 22,101,111,121; fifth call dropped
    step("ov_c1", M_CALL, 1'b0, 8'd100, 100, 1);
    step("ov_c2", M_CALL, 1'b0, 8'd110, 110, 2);
    step("ov_c3", M_CALL, 1'b0, 8'd120, 120, 3);
    step("ov_c4", M_CALL, 1'b0, 8'd130, 130, 4);
    flags("ov_c4", 0, 0);
    step("ov_c5", M_CALL, 1'b0, 8'd140, 140, 4);
    flags("ov_c5", 1, 0);
    step("ov_r1", M_RET, 1'b0, 8'd0, 121, 3);
    step("ov_r2", M_RET, 1'b0, 8'd0, 111, 2);
    step("ov_r3", M_RET, 1'b0, 8'd0, 101, 1);
    step("ov_r4", M_RET, 1'b0, 8'd0, 22, 0);
    flags("ov_r4", 1, 0);

    // underflow
    step("to7", M_JI, 1'b0, 8'd7, 7, 0);
    step("unf_ret", M_RET, 1'b0, 8'd0, 8, 0);
    flags("unf_ret", 1, 1);
    step("unf_hold", M_NOJ, 1'b0, 8'd0, 9, 0);
    flags("unf_hold", 1, 1);

    // stall with CALL pending
    en = 1'b0;
    step("stall1", M_CALL, 1'b0, 8'd50, 9, 0);
    step("stall2", M_CALL, 1'b0, 8'd50, 9, 0);
    step("stall3", M_CALL, 1'b0, 8'd50, 9, 0);
    flags("stall", 1, 1);
    en = 1'b1;
    step("unstall", M_CALL, 1'b0, 8'd50, 50, 1);
    step("after", M_NOJ, 1'b0, 8'd0, 51, 1);
    step("call_ret", M_CALL, 1'b0, 8'd70, 70, 2);
    step("ret_back", M_RET, 1'b0, 8'd0, 52, 1);

    // reset mid-stack, with en low: reset still wins
    rst = 1'b1; en = 1'b0;
    step("rst_mid", M_CALL, 1'b0, 8'd99, 0, 0);
    flags("rst_mid", 0, 0);
    rst = 1'b0; en = 1'b1;
    step("post_rst", M_RET, 1'b0, 8'd0, 1, 0);
    flags("post_rst", 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pc_unit

// File: doc/pc_unit.md
# pc_unit

Registered program-counter unit for the ReduxV core; successor to the combinational `next_pc` selector. It holds the architectural PC and computes the sequential PC internally. It also selects among register-branch, immediate-branch, jump, call and return targets, and keeps a hardware return-address stack of parametrised depth. It sits between the decoder/ALU and instruction memory: `pc` drives the fetch address.

## Interface
- `PC_W`, 8, PC and target width in bits.
- `RAS_DEPTH`, 4, return-address stack entries (≥1).
- `RESET_PC`, 0, PC value loaded on reset.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  advance PC this cycle; 0 = stall, all state held.
- `pcsrc`  in  3  next-PC mode (see Operation).
- `zero`  in  1  ALU zero flag, branch condition.
- `brzr_pc`  in  PC_W  register-indirect branch target.
- `brzi_pc`  in  PC_W  immediate branch target.
- `ji_pc`  in  PC_W  jump / call target.
- `pc`  out  PC_W  current PC (registered).
- `ras_count`  out  $clog2(RAS_DEPTH+1)  valid stack entries.
- `ras_ovf`  out  1  sticky overflow flag.
- `ras_unf`  out  1  sticky underflow flag.

## Operation
- `std_pc` = `pc` + 1, modulo 2^PC_W; `PC_W'(2^PC_W − 1)` wraps to 0.
- pcsrc encoding:
  - 000 BRZR: next = `zero` ? `brzr_pc` : `std_pc`.
  - 100 BRZI: next = `zero` ? `brzi_pc` : `std_pc`.
  - 101 JI: next = `ji_pc` unconditionally.
  - 110 NO_JMP: next = `std_pc`.
  - 001 CALL: next = `ji_pc`; push `std_pc` onto RAS.
  - 010 RET: next = top of RAS; pop.
  - 011, 111: treated as NO_JMP.
- `zero` is ignored for all modes except BRZR and BRZI.
- RAS is a LIFO: `ras_count` entries, top = entry `ras_count`−1.
- CALL with `ras_count` == RAS_DEPTH:
  - jump still taken;
  - push dropped, stack contents unchanged;
  - `ras_ovf` set.
- RET with `ras_count` == 0:
  - next = `std_pc`;
  - no pop;
  - `ras_unf` set.
- `ras_ovf` and `ras_unf` are sticky; only `rst` clears them.
- `en`=0: `pc`, stack, count and flags all hold; `pcsrc` is ignored entirely, so no push or pop occurs.

## Timing
- Reset, checked on rising edge when `rst`=1, overriding `en`:
  - `pc` = RESET_PC;
  - `ras_count` = 0;
  - `ras_ovf` = `ras_unf` = 0;
  - stack contents don't-care.
- Latency: one cycle. Inputs sampled at edge N appear on `pc` after edge N.
- `pc`, `ras_count` and flags are pure register outputs; there is no combinational input-to-output path.
- CALL then RET on consecutive enabled cycles: the RET sees the just-pushed entry, returning the CALL's `std_pc`.
- `rst` asserted mid-stack clears the count. Pending entries are lost and no flag is raised.

## Structure
- Shared package `reduxv_pkg`:
  - pcsrc localparams BRZR=3'b000, CALL=3'b001, RET=3'b010, BRZI=3'b100, JI=3'b101, NO_JMP=3'b110;
  - PC_W default.
- Sub-module `ras_stack`:
  - parametrised LIFO (width, depth);
  - push/pop inputs, `top`, `count`, `full`, `empty` outputs;
  - ignores push when full and pop when empty.
- `pc_unit` owns the mode decode, PC register and sticky flags.

## Test plan
- Reset and wrap: assert `rst` with `en`=1 → `pc`=0, count 0, flags 0. Then NO_JMP with PC_W=8 from `pc`=255 → `pc`=0.
- Branches from `pc`=10, targets brzr=13, brzi=12, ji=11:
  - BRZR with zero=0 → 11; with zero=1 → 13.
  - BRZI with zero=0 → `pc`+1; with zero=1 → 12.
  - JI → 11 regardless of zero.
- Call/return:
  - From `pc`=20, CALL with ji=40 → `pc`=40, count 1.
  - From 40, CALL with ji=60 → `pc`=60, count 2.
  - RET → 41; RET → 21; count 0, no flags.
- Overflow (RAS_DEPTH=4):
  - Five CALLs → count stays 4 and `ras_ovf`=1.
  - Four RETs return the first four pushed addresses in reverse order.
- Underflow: RET at count 0 from `pc`=7 → `pc`=8 and `ras_unf`=1. Flag remains 1 until `rst`.
- Stall: `en`=0 with CALL on pcsrc for 3 cycles → `pc`, count and flags unchanged. Raising `en` performs the CALL once.
